addsub_chunked: RTL and testbench

//  Parametrised multi-cycle adder/subtractor, LSB-first, CHUNK bits per clock.

---
 rtl/addsub_chunked.sv | 123 ++++++++++++
 tb/tb_addsub_chunked.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/addsub_chunked.sv
// addsub_chunked: multi-cycle LSB-first add/subtract, CHUNK bits per clock, with
// signed/unsigned overflow, optional saturation and valid/ready on both sides.
module addsub_chunked #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             signed_mode,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             overflow,
  output logic             carry
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("addsub_chunked: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             sub_q, sub_d, sm_q, sm_d, sat_q, sat_d;
  logic             cin_q, cin_d, ov_q, ov_d, cy_q, cy_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CHUNK-1:0] ac, bc;
  logic [CHUNK:0]   sum;
  logic [WIDTH-1:0] wrap;
  logic             last, ci_msb, ovf;

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign C         = c_q;
  assign overflow  = ov_q;
  assign carry     = cy_q;

  always_comb begin
    ac = a_q[idx_q*CHUNK +: CHUNK];
    bc = b_q[idx_q*CHUNK +: CHUNK];
    sum = {1'b0, ac} + {1'b0, bc} + {{CHUNK{1'b0}}, cin_q};
    wrap = c_q;
    wrap[idx_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    last = idx_q == IW'(NCHUNK - 1);
    // carry into the MSB recovered from the MSB sum bit and its operands
    ci_msb = sum[CHUNK-1] ^ ac[CHUNK-1] ^ bc[CHUNK-1];
    ovf = sm_q ? ci_msb ^ sum[CHUNK] : sum[CHUNK] ^ sub_q;
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    sub_d = sub_q;
    sm_d = sm_q;
    sat_d = sat_q;
    cin_d = cin_q;
    ov_d = ov_q;
    cy_d = cy_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = A;
        b_d = B ^ {WIDTH{sub}};
        sub_d = sub;
        sm_d = signed_mode;
        sat_d = sat;
        cin_d = sub;
        idx_d = '0;
        state_d = RUN;
      end
      RUN: begin
        c_d = wrap;
        cin_d = sum[CHUNK];
        idx_d = last ? '0 : idx_q + 1'b1;
        if (last) begin
          cy_d = sum[CHUNK];
          ov_d = ovf;
          state_d = DONE;
          if (sat_q && ovf)
            c_d = sm_q ? {~wrap[WIDTH-1], {(WIDTH-1){wrap[WIDTH-1]}}} : {WIDTH{~sub_q}};
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      sub_q <= 1'b0;
      sm_q <= 1'b0;
      sat_q <= 1'b0;
      cin_q <= 1'b0;
      ov_q <= 1'b0;
      cy_q <= 1'b0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      sub_q <= sub_d;
      sm_q <= sm_d;
      sat_q <= sat_d;
      cin_q <= cin_d;
      ov_q <= ov_d;
      cy_q <= cy_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: tb/tb_addsub_chunked.sv
// tb_addsub_chunked: scoreboard bench for addsub_chunked (16/4 and 16/16 configs).
module tb_addsub_chunked;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, sub = 1'b0, signed_mode = 1'b0, sat = 1'b0;
  logic        out_valid, out_ready = 1'b0, overflow, carry;
  logic [15:0] A = '0, B = '0, C;
  logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b0, overflow1, carry1;
  logic [15:0] A1 = '0, B1 = '0, C1;

  typedef struct packed {
    logic [15:0] c;
    logic        ov;
    logic        cy;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .sub(sub), .signed_mode(signed_mode), .sat(sat), .out_valid(out_valid),
    .out_ready(out_ready), .C(C), .overflow(overflow), .carry(carry)
  );

  addsub_chunked #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .A(A1), .B(B1),
    .sub(1'b0), .signed_mode(1'b0), .sat(1'b0), .out_valid(out_valid1),
    .out_ready(out_ready1), .C(C1), .overflow(overflow1), .carry(carry1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, b, input logic s, sm, st);
    logic [15:0] bv;
    logic [16:0] full;
    exp_t        e;
    bv = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bv} + 17'(s);
    e.c = full[15:0];
    e.cy = full[16];
    e.ov = sm ? (a[15] == bv[15]) && (e.c[15] != a[15]) : (s ? ~full[16] : full[16]);
    if (st && e.ov) e.c = sm ? (e.c[15] ? 16'h7FFF : 16'h8000) : (s ? 16'h0000 : 16'hFFFF);
    return e;
  endfunction

  task automatic run_op(input logic [15:0] a, b, input logic s, sm, st, input int hold);
    exp_t e;
    int   lat;
    sbq.push_back(model(a, b, s, sm, st));
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 1);
    A = a; B = b; sub = s; signed_mode = sm; sat = st; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency", 32'(lat), 4);
    e = sbq.pop_front();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      A = ~a; B = a ^ b; sub = ~s; in_valid = 1'b1;
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_c", 32'(C), 32'(e.c));
      chk("hold_flags", {30'd0, overflow, carry}, {30'd0, e.ov, e.cy});
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
    chk("c", 32'(C), 32'(e.c));
    chk("overflow", 32'(overflow), 32'(e.ov));
    chk("carry", 32'(carry), 32'(e.cy));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("back_idle", {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_c", 32'(C), 0);
    chk("rst_flags", {30'd0, overflow, carry}, 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1, 0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1, 0);
    run_op(16'h0003, 16'h0005, 1'b1, 1'b0, 1'b0, 0);
    run_op(16'h0003, 16'h0005, 1'b1, 1'b0, 1'b1, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1, 0);
    run_op(16'h0005, 16'h0003, 1'b1, 1'b0, 1'b1, 0);
    run_op(16'h0FF0, 16'h0010, 1'b0, 1'b0, 1'b0, 0);
    run_op(16'h1234, 16'h5678, 1'b1, 1'b1, 1'b0, 5);

    // abort an operation after its second chunk edge
    @(negedge clk);
    A = 16'hAAAA; B = 16'h5555; sub = 1'b0; signed_mode = 1'b0; sat = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_c", 32'(C), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    run_op(16'h1234, 16'h0101, 1'b0, 1'b1, 1'b0, 0);

    for (int i = 0; i < 24; i++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);

    @(negedge clk);
    A1 = 16'h00FF; B1 = 16'h0001; in_valid1 = 1'b1;
    @(posedge clk);
    #1 in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("n1_latency", 32'(lat), 1);
    chk("n1_c", 32'(C1), 32'h0100);
    chk("n1_flags", {30'd0, overflow1, carry1}, 0);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1 out_ready1 = 1'b0;
    chk("n1_idle", 32'(in_ready1), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
